ssd_display_driver: RTL
=======================

Name: ssd_display_driver

Overview:
- Downstream consumer of the CPU top's 13-bit SSD debug value (PC, ALU result, register data, etc.).
- Converts the value to four decimal digits with a sequential double-dabble FSM, or to four hex nibbles in hex mode.
- Time-multiplexes the digits onto a 4-digit common-anode seven-segment display.
- Sits between the CPU top and the board pins.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot (100 MHz gives 1 kHz per digit). Minimum 2.
- BLANK_LZ, 1: when 1, leading zeros are blanked (digit 0 is never blanked).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- value  in  13  binary value to display (0..8191)
- hex_mode  in  1  1 = show value zero-extended to 16 bits as 4 hex nibbles; 0 = decimal
- anode  out  4  digit enables, active-low; bit 0 = rightmost (ones) digit
- cathode  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low; constant 1 (off)
- busy  out  1  high while a conversion is in progress
- digits  out  16  latched display nibbles {d3,d2,d1,d0}, for debug

Behaviour:
- Reset values: anode=4'b1111, cathode=7'h7F, dp=1, busy=0, digits=0. The refresh counter, digit_sel, FSM state and last-value register are cleared, and force_conv=1.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - Start condition: {hex_mode,value} differs from the last-converted register, or force_conv=1.
  - On start, latch {hex_mode,value} into the last-converted register and clear force_conv.
  - hex_mode=1: go to DONE with result = {3'b0,value}.
  - hex_mode=0: load a 13-bit shift register with value, clear the 16-bit BCD accumulator, set bit count=0, go to CONV.
- CONV (busy=1):
  - Each cycle, add 3 to every BCD nibble that is >=5, then shift {bcd,bin} left by 1.
  - Increment the count. After the 13th shift, go to DONE.
- DONE (busy=1): load digits from the result and return to IDLE.
- Latency:
  - Decimal: digits update on the 15th rising edge after the edge at which IDLE samples the change. busy is high for 14 cycles.
  - Hex: digits update on the 2nd edge. busy is high for 1 cycle.
- value or hex_mode changes while in CONV/DONE are ignored until IDLE. IDLE then sees the mismatch and restarts, so the newest value is always eventually displayed. Intermediate values are never shown partially; digits change only in DONE.
- Refresh:
  - The counter runs 0..REFRESH_DIV-1. On wrap, digit_sel advances 0→1→2→3→0.
  - anode = ~(4'b0001 << digit_sel), registered. The anode/cathode pair for a slot appears together, one edge after digit_sel changes.
- Blanking (BLANK_LZ=1): digit k (k>0) outputs cathode=7'h7F when digits k..3 are all zero. Hex mode blanks identically.
- Segment codes for digits 0..F:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- rst mid-conversion: all outputs return to reset values on that edge and the conversion is abandoned. After release, force_conv triggers a fresh conversion of the current value.
- Before the first DONE after reset, digits=0: the display shows "0" on digit 0 with the other digits blanked.

Decomposition:
- Package ssd_pkg holds:
  - state typedef {IDLE, CONV, DONE}
  - NUM_DIGITS=4, BIN_W=13
  - the 16-entry active-low segment constant table
  - the blank code 7'h7F
- One sub-module: seg7_decoder, a combinational 4-bit nibble to 7-bit active-low cathode decoder using the package table. The top holds the FSM, the refresh counter and the blanking logic.

Test Plan (REFRESH_DIV=4 in simulation):
- Decimal conversion: release reset, hex_mode=0, value=1234 → busy high for 14 cycles; digits=16'h1234 on the 15th edge.
- Digit scan: value=8191 → digits=16'h8191. Scan shows anode=1110/cathode=1111001 ('1'), then after 4 cycles anode=1101/cathode=0010000 ('9'), then 1011/1111001, then 0111/0000000.
- Leading-zero blanking: value=7, BLANK_LZ=1 → digits 3..1 cathode=7F; digit 0 cathode=1111000. With BLANK_LZ=0, digits 3..1 show 1000000.
- Hex mode: hex_mode=1, value=13'h1ABC → digits=16'h1ABC after 2 edges; cathodes read 1111001, 0001000, 0000011, 1000110.
- Change during conversion: value 100 → 200 at the 5th CONV cycle → digits=16'h0100 first, then 16'h0200 exactly 15 edges after the return to IDLE.
- Reset mid-conversion: rst during CONV → next edge gives anode=1111, cathode=7F, busy=0, digits=0. After release with value=42, digits=16'h0042 on the 15th edge.

Source files
------------

// File: rtl/ssd_pkg.sv
// ---------------------------------------------------------------------------
// ssd_pkg
// Shared definitions for the seven-segment display driver:
//   state_t      - conversion FSM states
//   NUM_DIGITS   - number of display digits
//   BIN_W        - width of the binary value being displayed
//   SEG_TABLE    - active-low segment patterns {g,f,e,d,c,b,a} for 0..F
//   SEG_BLANK    - active-low pattern with every segment off
//   bcd_adjust() - double-dabble "add 3 to every nibble >= 5" step
// ---------------------------------------------------------------------------
package ssd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } state_t;

   localparam int NUM_DIGITS = 4;
   localparam int BIN_W      = 13;
   localparam int BCD_W      = 4 * NUM_DIGITS;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'b1000000,   // 0
      7'b1111001,   // 1
      7'b0100100,   // 2
      7'b0110000,   // 3
      7'b0011001,   // 4
      7'b0010010,   // 5
      7'b0000010,   // 6
      7'b1111000,   // 7
      7'b0000000,   // 8
      7'b0010000,   // 9
      7'b0001000,   // A
      7'b0000011,   // b
      7'b1000110,   // C
      7'b0100001,   // d
      7'b0000110,   // E
      7'b0001110    // F
   };

   // Any BCD nibble that is 5 or more would exceed 9 after the next
   // doubling, so it is pre-corrected by 3 before the shift.
   function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
      logic [BCD_W-1:0] res;
      res = bcd;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) begin
            res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// ---------------------------------------------------------------------------
// seg7_decoder
// Combinational hex nibble to active-low seven-segment pattern.
// Ports:
//   nibble  in  4  digit value 0..F
//   seg     out 7  segments {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module seg7_decoder
   import ssd_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/ssd_display_driver.sv
// ---------------------------------------------------------------------------
// ssd_display_driver
// Converts a 13-bit debug value to four decimal digits (sequential double
// dabble) or four hex nibbles, and scans them onto a 4-digit common-anode
// seven-segment display with optional leading-zero blanking.
// Parameters:
//   REFRESH_DIV  clk cycles per digit slot (>= 2)
//   BLANK_LZ     1 = blank leading zeros (digit 0 always shown)
// Ports:
//   clk       in  1   system clock
//   rst       in  1   synchronous, active-high reset
//   value     in  13  binary value to display
//   hex_mode  in  1   1 = hex display, 0 = decimal
//   anode     out 4   digit enables, active-low, bit 0 = ones digit
//   cathode   out 7   segments {g,f,e,d,c,b,a}, active-low
//   dp        out 1   decimal point, active-low, always off
//   busy      out 1   conversion in progress
//   digits    out 16  latched display nibbles {d3,d2,d1,d0}
// ---------------------------------------------------------------------------
module ssd_display_driver
   import ssd_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter bit BLANK_LZ    = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [BIN_W-1:0] value,
   input  logic             hex_mode,
   output logic [3:0]       anode,
   output logic [6:0]       cathode,
   output logic             dp,
   output logic             busy,
   output logic [BCD_W-1:0] digits
);

   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

   state_t           state;
   logic [BIN_W:0]   last_val;
   logic             force_conv;
   logic [BIN_W-1:0] bin_sr;
   logic [BCD_W-1:0] bcd;
   logic [BCD_W-1:0] bcd_adj;
   logic [3:0]       bit_cnt;
   logic             start;

   logic [CNT_W-1:0] refresh_cnt;
   logic [1:0]       digit_sel;
   logic [3:0]       cur_nibble;
   logic             cur_blank;
   logic [6:0]       cur_seg;

   assign bcd_adj = bcd_adjust(bcd);
   assign start   = ({hex_mode, value} != last_val) || force_conv;
   assign dp      = 1'b1;

   // Conversion FSM. The bcd register doubles as the result register: hex
   // mode loads it directly, decimal mode builds it one shift per cycle.
   // digits only ever changes in DONE, so partial results are never shown.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_val   <= '0;
         force_conv <= 1'b1;
         bin_sr     <= '0;
         bcd        <= '0;
         bit_cnt    <= '0;
         busy       <= 1'b0;
         digits     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  last_val   <= {hex_mode, value};
                  force_conv <= 1'b0;
                  busy       <= 1'b1;
                  if (hex_mode) begin
                     bcd   <= {3'b000, value};
                     state <= DONE;
                  end else begin
                     bin_sr  <= value;
                     bcd     <= '0;
                     bit_cnt <= '0;
                     state   <= CONV;
                  end
               end
            end
            CONV: begin
               {bcd, bin_sr} <= {bcd_adj, bin_sr} << 1;
               bit_cnt       <= bit_cnt + 4'd1;
               if (bit_cnt == 4'(BIN_W - 1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               digits <= bcd;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Select the nibble for the current slot. A digit above the ones digit
   // is blanked when it and every digit to its left are zero.
   always_comb begin
      cur_nibble = digits[3:0];
      cur_blank  = 1'b0;
      case (digit_sel)
         2'd0: begin
            cur_nibble = digits[3:0];
            cur_blank  = 1'b0;
         end
         2'd1: begin
            cur_nibble = digits[7:4];
            cur_blank  = (digits[15:4] == 12'd0);
         end
         2'd2: begin
            cur_nibble = digits[11:8];
            cur_blank  = (digits[15:8] == 8'd0);
         end
         default: begin
            cur_nibble = digits[15:12];
            cur_blank  = (digits[15:12] == 4'd0);
         end
      endcase
      cur_blank = cur_blank && BLANK_LZ;
   end

   seg7_decoder u_seg7_decoder (
      .nibble (cur_nibble),
      .seg    (cur_seg)
   );

   // Refresh scan. anode and cathode are registered from the same
   // digit_sel so the pair for a slot always changes together.
   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_cnt <= '0;
         digit_sel   <= '0;
         anode       <= 4'b1111;
         cathode     <= SEG_BLANK;
      end else begin
         if (refresh_cnt == CNT_MAX) begin
            refresh_cnt <= '0;
            digit_sel   <= digit_sel + 2'd1;
         end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
         end
         anode   <= ~(4'b0001 << digit_sel);
         cathode <= cur_blank ? SEG_BLANK : cur_seg;
      end
   end

endmodule
